sh7604_ibus_arbiter: RTL

//  Sequences the SH7604 on-chip peripheral bus (IBUS) and shares it between two masters: the CPU and the DMAC.

---
 rtl/sh7604_ibus_arbiter_pkg.sv | 29 ++
 rtl/sh7604_ibus_rdmux.sv | 30 +++
 rtl/sh7604_ibus_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sh7604_ibus_arbiter_pkg.sv
// sh7604_ibus_arbiter_pkg -- shared types for the SH7604 on-chip peripheral bus arbiter. Rev 1.0
`default_nettype none

package sh7604_ibus_arbiter_pkg;

   typedef enum logic [1:0] {
      IBUS_IDLE   = 2'd0,
      IBUS_ACCESS = 2'd1,
      IBUS_WAIT   = 2'd2,
      IBUS_DONE   = 2'd3
   } IBusState_t;

   typedef enum logic {
      MST_CPU = 1'b0,
      MST_DMA = 1'b1
   } IBusMaster_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] di;
      logic [3:0]  ba;
      logic        we;
   } IBusReq_t;

   localparam int IBUS_DW = 32;

endpackage

`default_nettype wire

// File: rtl/sh7604_ibus_rdmux.sv
// sh7604_ibus_rdmux -- AND-OR reduction of slave read data and wait-state requests. Rev 1.0
`default_nettype none

module sh7604_ibus_rdmux
   import sh7604_ibus_arbiter_pkg::*;
#(
   parameter int NSLV = 8
) (
   input  logic [NSLV*IBUS_DW-1:0] slv_do,
   input  logic [NSLV-1:0]         slv_act,
   input  logic [NSLV-1:0]         slv_busy,
   output logic [IBUS_DW-1:0]      rdata,
   output logic                    any_act,
   output logic                    any_busy
);

   // Overlapping decodes are ORed rather than prioritised; that case is a system bug.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         rdata = rdata | (slv_do[IBUS_DW*i +: IBUS_DW] & {IBUS_DW{slv_act[i]}});
      end
   end

   assign any_act  = |slv_act;
   assign any_busy = |(slv_act & slv_busy);

endmodule

`default_nettype wire

// File: rtl/sh7604_ibus_arbiter.sv
// sh7604_ibus_arbiter -- CPU/DMAC sharing of the SH7604 IBUS with starvation guard. Rev 1.0
// Optional slave-wait timeout enabled by defining SH7604_IBUS_TIMEOUT_EN.
`default_nettype none

module sh7604_ibus_arbiter
   import sh7604_ibus_arbiter_pkg::*;
#(
   parameter int NSLV    = 8,
   parameter int STARVE  = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce_r,
   input  logic                 ce_f,
   input  logic                 en,
   input  logic                 res_n,
   input  logic [31:0]          cpu_a,
   input  logic [31:0]          cpu_di,
   input  logic [3:0]           cpu_ba,
   input  logic                 cpu_we,
   input  logic                 cpu_req,
   input  logic [31:0]          dma_a,
   input  logic [31:0]          dma_di,
   input  logic [3:0]           dma_ba,
   input  logic                 dma_we,
   input  logic                 dma_req,
   output logic [31:0]          cpu_do,
   output logic [31:0]          dma_do,
   output logic                 cpu_busy,
   output logic                 dma_busy,
   output logic [31:0]          ibus_a,
   output logic [31:0]          ibus_di,
   output logic [3:0]           ibus_ba,
   output logic                 ibus_we,
   output logic                 ibus_req,
   input  logic [NSLV*32-1:0]   slv_do,
   input  logic [NSLV-1:0]      slv_act,
   input  logic [NSLV-1:0]      slv_busy,
   output logic                 gnt_dma,
   output logic                 bus_err
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE);
   localparam logic [3:0] TMO_LAST   = 4'(TIMEOUT - 1);

   IBusState_t  state, state_nx;
   IBusMaster_t owner;
   IBusReq_t    req_q;
   IBusReq_t    cpu_rq, dma_rq;
   logic [3:0]  starve_cnt;
   logic [31:0] rdata;
   logic        any_act, any_busy;
   logic        tick, any_req, grant_dma, owner_req, timeout, access_err;
   logic        unused_ok;

   assign tick      = ce_r & en;
   assign any_req   = cpu_req | dma_req;
   assign grant_dma = dma_req & ~(cpu_req & (starve_cnt >= STARVE_LIM));
   assign owner_req = (owner == MST_DMA) ? dma_req : cpu_req;
   assign cpu_rq    = {cpu_a, cpu_di, cpu_ba, cpu_we};
   assign dma_rq    = {dma_a, dma_di, dma_ba, dma_we};
   assign unused_ok = ^{ce_f, TMO_LAST};

   sh7604_ibus_rdmux #(.NSLV(NSLV)) u_rdmux (
      .slv_do   (slv_do),
      .slv_act  (slv_act),
      .slv_busy (slv_busy),
      .rdata    (rdata),
      .any_act  (any_act),
      .any_busy (any_busy)
   );

`ifdef SH7604_IBUS_TIMEOUT_EN
   logic [3:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (!res_n)
         wait_cnt <= '0;
      else if (tick)
         wait_cnt <= (state == IBUS_WAIT && state_nx == IBUS_WAIT) ? wait_cnt + 4'd1 : '0;
   end

   assign timeout = (state == IBUS_WAIT) && (wait_cnt == TMO_LAST);
`else
   assign timeout = 1'b0;
`endif

   assign access_err = ~any_act | (any_busy & timeout);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IBUS_IDLE;
      else if (!res_n)
         state <= IBUS_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (tick) begin
         case (state)
            IBUS_IDLE:   if (any_req) state_nx = IBUS_ACCESS;
            IBUS_ACCESS,
            IBUS_WAIT: begin
               if (!any_act)
                  state_nx = IBUS_DONE;
               else if (any_busy)
                  state_nx = timeout ? IBUS_DONE : IBUS_WAIT;
               else
                  state_nx = IBUS_DONE;
            end
            IBUS_DONE:   state_nx = IBUS_IDLE;
            default:     state_nx = IBUS_IDLE;
         endcase
      end
   end

   always_comb begin
      ibus_req = (state == IBUS_ACCESS) || (state == IBUS_WAIT);
      cpu_busy = cpu_req & ~(state == IBUS_DONE && owner == MST_CPU);
      dma_busy = dma_req & ~(state == IBUS_DONE && owner == MST_DMA);
      gnt_dma  = (owner == MST_DMA);
   end

   assign ibus_a  = req_q.a;
   assign ibus_di = req_q.di;
   assign ibus_ba = req_q.ba;
   assign ibus_we = req_q.we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= MST_CPU;
         req_q      <= '0;
         starve_cnt <= '0;
         cpu_do     <= '0;
         dma_do     <= '0;
         bus_err    <= 1'b0;
      end else if (!res_n) begin
         owner      <= MST_CPU;
         req_q      <= '0;
         starve_cnt <= '0;
         cpu_do     <= '0;
         dma_do     <= '0;
         bus_err    <= 1'b0;
      end else if (tick) begin
         bus_err <= 1'b0;
         case (state)
            IBUS_IDLE: begin
               if (any_req) begin
                  if (grant_dma) begin
                     owner <= MST_DMA;
                     req_q <= dma_rq;
                     if (cpu_req && starve_cnt != 4'hF)
                        starve_cnt <= starve_cnt + 4'd1;
                  end else begin
                     owner      <= MST_CPU;
                     req_q      <= cpu_rq;
                     starve_cnt <= '0;
                  end
               end
            end
            IBUS_ACCESS,
            IBUS_WAIT: begin
               if (access_err || !any_busy) begin
                  bus_err <= access_err;
                  // A master that has already withdrawn its request gets nothing back.
                  if (!req_q.we && owner_req) begin
                     if (owner == MST_DMA)
                        dma_do <= access_err ? '0 : rdata;
                     else
                        cpu_do <= access_err ? '0 : rdata;
                  end
               end
            end
            default: ;
         endcase
         if (!cpu_req)
            starve_cnt <= '0;
      end
   end

endmodule

`default_nettype wire
